// File: rtl/pbus_xbar_pkg.sv
// Shared constants, types and helpers for the peripheral bus crossbar.
// Bus geometry, default slave map and fault classification codes.
package pbus_xbar_pkg;

    localparam int XLEN        = 32;
    localparam int BUS_WIDTH   = 32;
    localparam int BUS_ACC_CNT = 4;
    localparam int ACC_W       = $clog2(BUS_ACC_CNT);
    localparam int PBUS_SPAN_W = 6;

    localparam logic [XLEN-1:0] EIC_BASE  = 32'h1000_0000;
    localparam logic [XLEN-1:0] UART_BASE = 32'h1000_0100;
    localparam logic [XLEN-1:0] GPIO_BASE = 32'h1000_0200;
    localparam logic [XLEN-1:0] TMR_BASE  = 32'h1000_0300;
    localparam logic [XLEN-1:0] RST_BASE  = 32'h1000_0400;

    localparam int EIC_SIZE  = 256;
    localparam int UART_SIZE = 256;
    localparam int GPIO_SIZE = 256;
    localparam int TMR_SIZE  = 256;
    localparam int RST_SIZE  = 256;

    localparam logic [5*XLEN-1:0] PBUS_BASE_VEC = {
        RST_BASE, TMR_BASE, GPIO_BASE, UART_BASE, EIC_BASE
    };

    localparam logic [5*PBUS_SPAN_W-1:0] PBUS_SPAN_VEC = {
        PBUS_SPAN_W'($clog2(RST_SIZE)),
        PBUS_SPAN_W'($clog2(TMR_SIZE)),
        PBUS_SPAN_W'($clog2(GPIO_SIZE)),
        PBUS_SPAN_W'($clog2(UART_SIZE)),
        PBUS_SPAN_W'($clog2(EIC_SIZE))
    };

    typedef enum logic [1:0] {
        PBUS_FAULT_NONE      = 2'd0,
        PBUS_FAULT_UNMAPPED  = 2'd1,
        PBUS_FAULT_COLLISION = 2'd2,
        PBUS_FAULT_TIMEOUT   = 2'd3
    } pbus_fault_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } pbus_state_e;

    // True when addr falls inside the 2^span byte region starting at base.
    function automatic logic pbus_region_hit(
        input logic [XLEN-1:0]        addr,
        input logic [XLEN-1:0]        base,
        input logic [PBUS_SPAN_W-1:0] span
    );
        logic [XLEN-1:0] mask;
        mask = (XLEN'(1) << span) - XLEN'(1);
        return (addr & ~mask) == base;
    endfunction

endpackage

// File: rtl/pbus_addr_dec.sv
// Combinational address decoder for peripheral bus connectors.
// Lowest-indexed matching region wins when regions overlap.
module pbus_addr_dec
    import pbus_xbar_pkg::*;
#(
    parameter int                               SLAVE_CNT = 5,
    parameter logic [SLAVE_CNT*XLEN-1:0]        BASE_VEC  = PBUS_BASE_VEC,
    parameter logic [SLAVE_CNT*PBUS_SPAN_W-1:0] SPAN_VEC  = PBUS_SPAN_VEC,
    parameter int                               IDX_W     = 3
) (
    input  logic [XLEN-1:0]      addr_i,
    output logic [SLAVE_CNT-1:0] sel_o,
    output logic                 hit_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic [SLAVE_CNT-1:0] match;

    // Raw per-region match, possibly several bits set.
    always_comb begin
        match = '0;
        for (int i = 0; i < SLAVE_CNT; i++) begin
            match[i] = pbus_region_hit(
                addr_i,
                BASE_VEC[i*XLEN +: XLEN],
                SPAN_VEC[i*PBUS_SPAN_W +: PBUS_SPAN_W]
            );
        end
    end

    // Priority pick: scanning downwards leaves the lowest match in place.
    always_comb begin
        sel_o = '0;
        idx_o = '0;
        for (int i = SLAVE_CNT - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_o    = '0;
                sel_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
    end

    assign hit_o = |match;

endmodule

// File: rtl/pbus_xbar.sv
// Single-master peripheral bus crossbar with one outstanding transaction,
// per-transaction timeout, halt/abandon and classified fault reporting.
module pbus_xbar
    import pbus_xbar_pkg::*;
#(
    parameter int                               SLAVE_CNT = 5,
    parameter logic [SLAVE_CNT*XLEN-1:0]        BASE_VEC  = PBUS_BASE_VEC,
    parameter logic [SLAVE_CNT*PBUS_SPAN_W-1:0] SPAN_VEC  = PBUS_SPAN_VEC,
    parameter int                               TIMEOUT   = 64,
    parameter int                               TO_W      = $clog2(TIMEOUT + 1)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           m_req,
    input  logic [XLEN-1:0]                m_addr,
    input  logic                           m_w_rb,
    input  logic [ACC_W-1:0]               m_acc,
    input  logic [BUS_WIDTH-1:0]           m_wdata,
    output logic                           m_resp,
    output logic [BUS_WIDTH-1:0]           m_rdata,
    output logic [SLAVE_CNT-1:0]           s_req,
    output logic [SLAVE_CNT*XLEN-1:0]      s_addr,
    output logic [SLAVE_CNT-1:0]           s_w_rb,
    output logic [SLAVE_CNT*ACC_W-1:0]     s_acc,
    output logic [SLAVE_CNT*BUS_WIDTH-1:0] s_wdata,
    input  logic [SLAVE_CNT-1:0]           s_resp,
    input  logic [SLAVE_CNT*BUS_WIDTH-1:0] s_rdata,
    output logic                           bus_fault,
    output logic [1:0]                     fault_code,
    input  logic                           bus_halt,
    output logic                           busy
);

    localparam int IDX_W = (SLAVE_CNT > 1) ? $clog2(SLAVE_CNT) : 1;

    pbus_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TO_W-1:0]      cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_d;

    logic [SLAVE_CNT-1:0] hit_sel;
    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;

    logic                 hit_resp;
    logic [BUS_WIDTH-1:0] hit_rdata;
    logic                 own_resp;
    logic [BUS_WIDTH-1:0] own_rdata;
    logic                 to_expire;

    pbus_addr_dec #(
        .SLAVE_CNT (SLAVE_CNT),
        .BASE_VEC  (BASE_VEC),
        .SPAN_VEC  (SPAN_VEC),
        .IDX_W     (IDX_W)
    ) u_dec (
        .addr_i (m_addr),
        .sel_o  (hit_sel),
        .hit_o  (hit),
        .idx_o  (hit_idx)
    );

    // Master fields are broadcast; only s_req is steered.
    assign s_addr  = {SLAVE_CNT{m_addr}};
    assign s_w_rb  = {SLAVE_CNT{m_w_rb}};
    assign s_acc   = {SLAVE_CNT{m_acc}};
    assign s_wdata = {SLAVE_CNT{m_wdata}};

    assign hit_resp  = s_resp[hit_idx];
    assign hit_rdata = s_rdata[hit_idx*BUS_WIDTH +: BUS_WIDTH];
    assign own_resp  = s_resp[idx_q];
    assign own_rdata = s_rdata[idx_q*BUS_WIDTH +: BUS_WIDTH];
    assign to_expire = (cnt_q == TO_W'(TIMEOUT - 1));

    assign busy = (state_q == ST_BUSY);

    // State and transaction bookkeeping registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: launch, complete, time out or abandon on halt.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (m_req && !bus_halt && hit) begin
                    if (hit_resp) begin
                        rdata_d = hit_rdata;
                    end else begin
                        state_d = ST_BUSY;
                        idx_d   = hit_idx;
                        cnt_d   = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (bus_halt) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (own_resp) begin
                    rdata_d = own_rdata;
                    state_d = ST_IDLE;
                end else if (to_expire) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: steering, master response and fault classification.
    always_comb begin
        s_req      = '0;
        m_resp     = 1'b0;
        m_rdata    = rdata_q;
        bus_fault  = 1'b0;
        fault_code = PBUS_FAULT_NONE;
        unique case (state_q)
            ST_IDLE: begin
                if (m_req && !bus_halt) begin
                    if (hit) begin
                        s_req = hit_sel;
                        if (hit_resp) begin
                            m_resp  = 1'b1;
                            m_rdata = hit_rdata;
                        end
                    end else begin
                        bus_fault  = 1'b1;
                        fault_code = PBUS_FAULT_UNMAPPED;
                    end
                end
            end
            ST_BUSY: begin
                if (!bus_halt) begin
                    if (own_resp) begin
                        m_resp  = 1'b1;
                        m_rdata = own_rdata;
                    end else if (to_expire) begin
                        m_resp     = 1'b1;
                        m_rdata    = '0;
                        bus_fault  = 1'b1;
                        fault_code = PBUS_FAULT_TIMEOUT;
                    end
                    // A colliding request outranks a same-cycle timeout.
                    if (m_req) begin
                        bus_fault  = 1'b1;
                        fault_code = PBUS_FAULT_COLLISION;
                    end
                end
            end
            default: begin
                s_req = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pbus_xbar.sv
// Randomized and directed bench for pbus_xbar against a
// transaction-level reference model of the bus connector.
module tb_pbus_xbar;
    import pbus_xbar_pkg::*;

    localparam int NS   = 5;
    localparam int TOUT = 8;

    logic                     clk;
    logic                     rstn;
    logic                     m_req;
    logic [31:0]              m_addr;
    logic                     m_w_rb;
    logic [ACC_W-1:0]         m_acc;
    logic [31:0]              m_wdata;
    logic                     m_resp;
    logic [31:0]              m_rdata;
    logic [NS-1:0]            s_req;
    logic [NS*32-1:0]         s_addr;
    logic [NS-1:0]            s_w_rb;
    logic [NS*ACC_W-1:0]      s_acc;
    logic [NS*32-1:0]         s_wdata;
    logic [NS-1:0]            s_resp;
    logic [NS*32-1:0]         s_rdata;
    logic                     bus_fault;
    logic [1:0]               fault_code;
    logic                     bus_halt;
    logic                     busy;

    int total = 0;
    int bad   = 0;

    // Reference model: which slave owns the bus, how long it has waited,
    // and the last data handed to the master.
    int          owner = -1;
    int          age   = 0;
    logic [31:0] last  = '0;

    pbus_xbar #(
        .SLAVE_CNT (NS),
        .TIMEOUT   (TOUT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .m_req      (m_req),
        .m_addr     (m_addr),
        .m_w_rb     (m_w_rb),
        .m_acc      (m_acc),
        .m_wdata    (m_wdata),
        .m_resp     (m_resp),
        .m_rdata    (m_rdata),
        .s_req      (s_req),
        .s_addr     (s_addr),
        .s_w_rb     (s_w_rb),
        .s_acc      (s_acc),
        .s_wdata    (s_wdata),
        .s_resp     (s_resp),
        .s_rdata    (s_rdata),
        .bus_fault  (bus_fault),
        .fault_code (fault_code),
        .bus_halt   (bus_halt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory map: five 256-byte windows starting at 0x1000_0000.
    function automatic int region_of(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (a >= 32'h1000_0000 + 32'(i) * 256 &&
                a <  32'h1000_0000 + 32'(i + 1) * 256)
                return i;
        end
        return -1;
    endfunction

    task automatic drive_idle();
        m_req    = 1'b0;
        s_resp   = '0;
        bus_halt = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a);
        m_req   = 1'b1;
        m_addr  = a;
        m_w_rb  = 1'($urandom);
        m_acc   = ACC_W'($urandom);
        m_wdata = $urandom;
    endtask

    task automatic set_rdata(input int i, input logic [31:0] v);
        s_rdata[i*32 +: 32] = v;
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance model.
    task automatic cycle();
        logic        e_resp;
        logic        e_fault;
        logic [1:0]  e_code;
        logic [31:0] e_data;
        logic [NS-1:0] e_sreq;
        int          d;
        int          n_owner;
        int          n_age;
        logic [31:0] n_last;
        int          k;
        @(negedge clk);
        e_resp  = 1'b0;
        e_fault = 1'b0;
        e_code  = 2'd0;
        e_data  = last;
        e_sreq  = '0;
        n_owner = owner;
        n_age   = age;
        n_last  = last;
        if (owner < 0) begin
            if (m_req && !bus_halt) begin
                d = region_of(m_addr);
                if (d < 0) begin
                    e_fault = 1'b1;
                    e_code  = 2'd1;
                end else begin
                    e_sreq[d] = 1'b1;
                    if (s_resp[d]) begin
                        e_resp = 1'b1;
                        e_data = s_rdata[d*32 +: 32];
                        n_last = e_data;
                    end else begin
                        n_owner = d;
                        n_age   = 0;
                    end
                end
            end
        end else if (bus_halt) begin
            n_owner = -1;
        end else begin
            if (s_resp[owner]) begin
                e_resp  = 1'b1;
                e_data  = s_rdata[owner*32 +: 32];
                n_last  = e_data;
                n_owner = -1;
            end else if (age + 1 == TOUT) begin
                e_resp  = 1'b1;
                e_data  = '0;
                e_fault = 1'b1;
                e_code  = 2'd3;
                n_owner = -1;
            end else begin
                n_age = age + 1;
            end
            if (m_req) begin
                e_fault = 1'b1;
                e_code  = 2'd2;
            end
        end
        check("m_resp", 64'(m_resp), 64'(e_resp));
        check("m_rdata", 64'(m_rdata), 64'(e_data));
        check("bus_fault", 64'(bus_fault), 64'(e_fault));
        if (e_fault) check("fault_code", 64'(fault_code), 64'(e_code));
        check("busy", 64'(busy), 64'(owner >= 0));
        check("s_req", 64'(s_req), 64'(e_sreq));
        k = $urandom_range(0, NS - 1);
        check("s_addr", 64'(s_addr[k*32 +: 32]), 64'(m_addr));
        check("s_wdata", 64'(s_wdata[k*32 +: 32]), 64'(m_wdata));
        @(posedge clk);
        owner = n_owner;
        age   = n_age;
        last  = n_last;
        #1;
    endtask

    initial begin
        rstn    = 1'b0;
        m_addr  = '0;
        m_w_rb  = 1'b0;
        m_acc   = '0;
        m_wdata = '0;
        s_rdata = '0;
        drive_idle();
        #2;
        check("rst_resp", 64'(m_resp), 64'd0);
        check("rst_rdata", 64'(m_rdata), 64'd0);
        check("rst_fault", 64'(bus_fault), 64'd0);
        check("rst_code", 64'(fault_code), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sreq", 64'(s_req), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cycle();

        // UART read answered three cycles after the request.
        issue(32'h1000_0104);
        cycle();
        drive_idle();
        cycle();
        cycle();
        s_resp[1] = 1'b1;
        set_rdata(1, 32'h1234_5678);
        cycle();
        drive_idle();
        cycle();
        check("uart_hold", 64'(m_rdata), 64'h1234_5678);

        // GPIO zero-wait completion.
        issue(32'h1000_0200);
        s_resp[2] = 1'b1;
        set_rdata(2, 32'h0000_00A5);
        cycle();
        drive_idle();
        check("gpio_nobusy", 64'(busy), 64'd0);
        cycle();

        // Unmapped address and region edges.
        issue(32'hDEAD_0000);
        cycle();
        issue(32'h1000_0500);
        cycle();
        issue(32'h1000_04FF);
        cycle();
        drive_idle();
        s_resp[4] = 1'b1;
        cycle();
        drive_idle();

        // TMR never answers: abort, then a late answer is ignored.
        issue(32'h1000_0300);
        cycle();
        drive_idle();
        for (int i = 1; i <= 9; i++) cycle();
        s_resp[3] = 1'b1;
        set_rdata(3, 32'hBEEF_0001);
        cycle();
        drive_idle();
        cycle();

        // Collision while EIC is outstanding; RST answer ignored.
        issue(32'h1000_0000);
        cycle();
        issue(32'h1000_0400);
        s_resp[4] = 1'b1;
        cycle();
        drive_idle();
        s_resp[0] = 1'b1;
        set_rdata(0, 32'h0000_0001);
        cycle();
        drive_idle();
        cycle();
        check("eic_hold", 64'(m_rdata), 64'h1);

        // Halt abandons an outstanding GPIO transaction.
        issue(32'h1000_0210);
        cycle();
        drive_idle();
        bus_halt = 1'b1;
        s_resp[2] = 1'b1;
        cycle();
        drive_idle();
        check("halt_busy", 64'(busy), 64'd0);
        s_resp[2] = 1'b1;
        cycle();
        drive_idle();

        // Asynchronous reset in the middle of a TMR transaction.
        issue(32'h1000_0300);
        cycle();
        drive_idle();
        cycle();
        #2;
        rstn = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_rdata", 64'(m_rdata), 64'd0);
        check("arst_resp", 64'(m_resp), 64'd0);
        owner = -1;
        age   = 0;
        last  = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        s_resp[3] = 1'b1;
        cycle();
        drive_idle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int sel;
            for (int i = 0; i < NS; i++) begin
                s_rdata[i*32 +: 32] = $urandom;
                s_resp[i] = ($urandom_range(0, 7) == 0);
            end
            bus_halt = ($urandom_range(0, 24) == 0);
            m_req = 1'b0;
            if (!bus_halt && $urandom_range(0, 2) == 0) begin
                sel = $urandom_range(0, 6);
                if (sel < NS)
                    issue(32'h1000_0000 + 32'(sel) * 256 +
                          32'($urandom_range(0, 255)));
                else if (sel == NS)
                    issue(32'h1000_0500);
                else
                    issue($urandom);
            end else begin
                m_addr  = $urandom;
                m_wdata = $urandom;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
